// File: rtl/execute_operand_receiver_fwd_if.sv
// ----------------------------------------------------------------------------
// execute_operand_receiver_fwd_if
//
// Bundles every non-clock/reset signal of the execute-stage operand receiver.
//
//   Decode side      : in_valid, opcode_in, dest_in, s1_in, s2_in, imm_in,
//                      data_s1_in, data_s2_in
//   Execute forward  : ex_fwd_valid, ex_fwd_dest, ex_fwd_data, ex_fwd_pending
//   Writeback forward: wb_fwd_valid, wb_fwd_dest, wb_fwd_data
//   Pipeline control : stall_in, flush_in
//   Registered out   : a_out, b_out, imm_out, opcode_out, dest_out, out_valid,
//                      fwd_sel_a, fwd_sel_b
//   Upstream request : hazard_stall (combinational)
//
// The master modport is the surrounding pipeline; the slave modport is the
// receiver itself.
// ----------------------------------------------------------------------------
interface execute_operand_receiver_fwd_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 4,
    parameter int unsigned OPC_W  = 5
);
    // Decode stage
    logic              in_valid;
    logic [OPC_W-1:0]  opcode_in;
    logic [REG_W-1:0]  dest_in;
    logic [REG_W-1:0]  s1_in;
    logic [REG_W-1:0]  s2_in;
    logic [DATA_W-1:0] imm_in;
    logic [DATA_W-1:0] data_s1_in;
    logic [DATA_W-1:0] data_s2_in;

    // Execute-stage forwarding
    logic              ex_fwd_valid;
    logic [REG_W-1:0]  ex_fwd_dest;
    logic [DATA_W-1:0] ex_fwd_data;
    logic              ex_fwd_pending;

    // Writeback-stage forwarding
    logic              wb_fwd_valid;
    logic [REG_W-1:0]  wb_fwd_dest;
    logic [DATA_W-1:0] wb_fwd_data;

    // Pipeline control
    logic              stall_in;
    logic              flush_in;

    // Registered outputs
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;
    logic [DATA_W-1:0] imm_out;
    logic [OPC_W-1:0]  opcode_out;
    logic [REG_W-1:0]  dest_out;
    logic              out_valid;
    logic [1:0]        fwd_sel_a;
    logic [1:0]        fwd_sel_b;

    // Combinational hold request to decode
    logic              hazard_stall;

    modport master (
        output in_valid, opcode_in, dest_in, s1_in, s2_in, imm_in,
               data_s1_in, data_s2_in,
               ex_fwd_valid, ex_fwd_dest, ex_fwd_data, ex_fwd_pending,
               wb_fwd_valid, wb_fwd_dest, wb_fwd_data,
               stall_in, flush_in,
        input  a_out, b_out, imm_out, opcode_out, dest_out, out_valid,
               fwd_sel_a, fwd_sel_b, hazard_stall
    );

    modport slave (
        input  in_valid, opcode_in, dest_in, s1_in, s2_in, imm_in,
               data_s1_in, data_s2_in,
               ex_fwd_valid, ex_fwd_dest, ex_fwd_data, ex_fwd_pending,
               wb_fwd_valid, wb_fwd_dest, wb_fwd_data,
               stall_in, flush_in,
        output a_out, b_out, imm_out, opcode_out, dest_out, out_valid,
               fwd_sel_a, fwd_sel_b, hazard_stall
    );
endinterface

// File: rtl/execute_operand_receiver_fwd.sv
// ----------------------------------------------------------------------------
// execute_operand_receiver_fwd
//
// Execute-stage input register. Each cycle it captures the decoded
// instruction and picks each source operand from execute-stage forwarding,
// writeback-stage forwarding or the register-file read, in that priority.
// A load still in flight in execute (ex_fwd_pending) that feeds a source of
// the incoming instruction raises hazard_stall and inserts a bubble.
//
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; clears every registered output
//   bus   - slave side of execute_operand_receiver_fwd_if (decode inputs,
//           forwarding inputs, stall/flush, registered outputs, hazard_stall)
//
// Parameters:
//   DATA_W      - operand / immediate / result width
//   REG_W       - register address width
//   OPC_W       - opcode width
//   ZERO_REG_EN - when non-zero, register 0 is never forwarded and never
//                 causes a hazard
// ----------------------------------------------------------------------------
module execute_operand_receiver_fwd #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned REG_W       = 4,
    parameter int unsigned OPC_W       = 5,
    parameter int unsigned ZERO_REG_EN = 0
) (
    input logic                          clk,
    input logic                          reset,
    execute_operand_receiver_fwd_if.slave bus
);

    // Operand source encoding reported on fwd_sel_a / fwd_sel_b
    localparam logic [1:0] SelRegFile  = 2'b00;
    localparam logic [1:0] SelExecute  = 2'b01;
    localparam logic [1:0] SelWriteback = 2'b10;

    // ------------------------------------------------------------------------
    // Source/destination matching
    // ------------------------------------------------------------------------
    function automatic logic src_match(
        input logic             stage_valid,
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] stage_dest
    );
        logic zero_excluded;
        zero_excluded = (ZERO_REG_EN != 0) && (src == '0);
        return stage_valid && (src == stage_dest) && !zero_excluded;
    endfunction

    logic ex_hit_a;
    logic ex_hit_b;
    logic wb_hit_a;
    logic wb_hit_b;
    logic load_use;

    assign ex_hit_a = src_match(bus.ex_fwd_valid, bus.s1_in, bus.ex_fwd_dest);
    assign ex_hit_b = src_match(bus.ex_fwd_valid, bus.s2_in, bus.ex_fwd_dest);
    assign wb_hit_a = src_match(bus.wb_fwd_valid, bus.s1_in, bus.wb_fwd_dest);
    assign wb_hit_b = src_match(bus.wb_fwd_valid, bus.s2_in, bus.wb_fwd_dest);

    // A pending execute result cannot be forwarded yet; decode has to wait.
    assign load_use = bus.in_valid && bus.ex_fwd_pending && (ex_hit_a || ex_hit_b);

    // Suppressed during reset so upstream is never held by stale inputs.
    assign bus.hazard_stall = load_use && !reset;

    // ------------------------------------------------------------------------
    // Operand selection
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;
    logic [1:0]        sel_a;
    logic [1:0]        sel_b;

    // A pending execute match falls through to writeback/regfile here; that
    // value is only ever captured when no hazard is raised (in_valid=0).
    always_comb begin
        opnd_a = bus.data_s1_in;
        sel_a  = SelRegFile;
        if (ex_hit_a && !bus.ex_fwd_pending) begin
            opnd_a = bus.ex_fwd_data;
            sel_a  = SelExecute;
        end else if (wb_hit_a) begin
            opnd_a = bus.wb_fwd_data;
            sel_a  = SelWriteback;
        end
    end

    always_comb begin
        opnd_b = bus.data_s2_in;
        sel_b  = SelRegFile;
        if (ex_hit_b && !bus.ex_fwd_pending) begin
            opnd_b = bus.ex_fwd_data;
            sel_b  = SelExecute;
        end else if (wb_hit_b) begin
            opnd_b = bus.wb_fwd_data;
            sel_b  = SelWriteback;
        end
    end

    // ------------------------------------------------------------------------
    // Stage register
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] a_q,     a_d;
    logic [DATA_W-1:0] b_q,     b_d;
    logic [DATA_W-1:0] imm_q,   imm_d;
    logic [OPC_W-1:0]  opc_q,   opc_d;
    logic [REG_W-1:0]  dest_q,  dest_d;
    logic              valid_q, valid_d;
    logic [1:0]        sel_a_q, sel_a_d;
    logic [1:0]        sel_b_q, sel_b_d;

    // Priority: flush > stall > hazard bubble > normal load.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        opc_d   = opc_q;
        dest_d  = dest_q;
        valid_d = valid_q;
        sel_a_d = sel_a_q;
        sel_b_d = sel_b_q;

        if (bus.flush_in) begin
            a_d     = '0;
            b_d     = '0;
            imm_d   = '0;
            opc_d   = '0;
            dest_d  = '0;
            valid_d = 1'b0;
            sel_a_d = SelRegFile;
            sel_b_d = SelRegFile;
        end else if (bus.stall_in) begin
            // Downstream busy: everything keeps its value.
            valid_d = valid_q;
        end else if (load_use) begin
            // Bubble: control fields cleared, data fields left as they were.
            opc_d   = '0;
            dest_d  = '0;
            valid_d = 1'b0;
            sel_a_d = SelRegFile;
            sel_b_d = SelRegFile;
        end else begin
            a_d     = opnd_a;
            b_d     = opnd_b;
            imm_d   = bus.imm_in;
            opc_d   = bus.opcode_in;
            dest_d  = bus.dest_in;
            valid_d = bus.in_valid;
            sel_a_d = sel_a;
            sel_b_d = sel_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            opc_q   <= '0;
            dest_q  <= '0;
            valid_q <= 1'b0;
            sel_a_q <= SelRegFile;
            sel_b_q <= SelRegFile;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            opc_q   <= opc_d;
            dest_q  <= dest_d;
            valid_q <= valid_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

    assign bus.a_out      = a_q;
    assign bus.b_out      = b_q;
    assign bus.imm_out    = imm_q;
    assign bus.opcode_out = opc_q;
    assign bus.dest_out   = dest_q;
    assign bus.out_valid  = valid_q;
    assign bus.fwd_sel_a  = sel_a_q;
    assign bus.fwd_sel_b  = sel_b_q;

endmodule

// File: tb/tb_execute_operand_receiver_fwd.sv
// ----------------------------------------------------------------------------
// tb_execute_operand_receiver_fwd
//
// Two receivers (ZERO_REG_EN=0 and ZERO_REG_EN=1) share one stimulus stream.
// A table of fixed vectors, hand-written corner sequences and random traffic
// are each compared against a behavioural model of the stage.
// ----------------------------------------------------------------------------
module tb_execute_operand_receiver_fwd;

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 4;
    localparam int unsigned OW = 5;

    typedef struct packed {
        logic          reset;
        logic          in_valid;
        logic [OW-1:0] opc;
        logic [RW-1:0] dest;
        logic [RW-1:0] s1;
        logic [RW-1:0] s2;
        logic [DW-1:0] imm;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic          exv;
        logic [RW-1:0] exd;
        logic [DW-1:0] exdata;
        logic          expend;
        logic          wbv;
        logic [RW-1:0] wbd;
        logic [DW-1:0] wbdata;
        logic          stall;
        logic          flush;
    } stim_t;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] imm;
        logic [OW-1:0] opc;
        logic [RW-1:0] dest;
        logic          ov;
        logic [1:0]    sa;
        logic [1:0]    sb;
    } out_t;

    typedef struct {
        stim_t s;
        out_t  e;
        logic  haz;
    } vec_t;

    logic  clk;
    logic  reset;
    stim_t cur;
    out_t  act0, act1;
    out_t  exp0, exp1;
    int    checks;
    int    failures;

    execute_operand_receiver_fwd_if #(.DATA_W(DW), .REG_W(RW), .OPC_W(OW)) bus0 ();
    execute_operand_receiver_fwd_if #(.DATA_W(DW), .REG_W(RW), .OPC_W(OW)) bus1 ();

    execute_operand_receiver_fwd #(
        .DATA_W(DW), .REG_W(RW), .OPC_W(OW), .ZERO_REG_EN(0)
    ) u_dut0 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus0)
    );

    execute_operand_receiver_fwd #(
        .DATA_W(DW), .REG_W(RW), .OPC_W(OW), .ZERO_REG_EN(1)
    ) u_dut1 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign reset = cur.reset;

    assign bus0.in_valid = cur.in_valid;   assign bus1.in_valid = cur.in_valid;
    assign bus0.opcode_in = cur.opc;       assign bus1.opcode_in = cur.opc;
    assign bus0.dest_in = cur.dest;        assign bus1.dest_in = cur.dest;
    assign bus0.s1_in = cur.s1;            assign bus1.s1_in = cur.s1;
    assign bus0.s2_in = cur.s2;            assign bus1.s2_in = cur.s2;
    assign bus0.imm_in = cur.imm;          assign bus1.imm_in = cur.imm;
    assign bus0.data_s1_in = cur.d1;       assign bus1.data_s1_in = cur.d1;
    assign bus0.data_s2_in = cur.d2;       assign bus1.data_s2_in = cur.d2;
    assign bus0.ex_fwd_valid = cur.exv;    assign bus1.ex_fwd_valid = cur.exv;
    assign bus0.ex_fwd_dest = cur.exd;     assign bus1.ex_fwd_dest = cur.exd;
    assign bus0.ex_fwd_data = cur.exdata;  assign bus1.ex_fwd_data = cur.exdata;
    assign bus0.ex_fwd_pending = cur.expend; assign bus1.ex_fwd_pending = cur.expend;
    assign bus0.wb_fwd_valid = cur.wbv;    assign bus1.wb_fwd_valid = cur.wbv;
    assign bus0.wb_fwd_dest = cur.wbd;     assign bus1.wb_fwd_dest = cur.wbd;
    assign bus0.wb_fwd_data = cur.wbdata;  assign bus1.wb_fwd_data = cur.wbdata;
    assign bus0.stall_in = cur.stall;      assign bus1.stall_in = cur.stall;
    assign bus0.flush_in = cur.flush;      assign bus1.flush_in = cur.flush;

    assign act0 = {bus0.a_out, bus0.b_out, bus0.imm_out, bus0.opcode_out, bus0.dest_out,
                   bus0.out_valid, bus0.fwd_sel_a, bus0.fwd_sel_b};
    assign act1 = {bus1.a_out, bus1.b_out, bus1.imm_out, bus1.opcode_out, bus1.dest_out,
                   bus1.out_valid, bus1.fwd_sel_a, bus1.fwd_sel_b};

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    function automatic bit m_match(logic v, logic [RW-1:0] x, logic [RW-1:0] d, bit zr);
        return (v == 1'b1) && (x == d) && !(zr && (x == 0));
    endfunction

    function automatic bit model_haz(stim_t s, bit zr);
        bit hit;
        hit = m_match(s.exv, s.s1, s.exd, zr) || m_match(s.exv, s.s2, s.exd, zr);
        return !s.reset && s.in_valid && s.expend && hit;
    endfunction

    // Returns {sel, data} for one source register.
    function automatic logic [DW+1:0] m_opnd(stim_t s, logic [RW-1:0] x, logic [DW-1:0] rf,
                                             bit zr);
        if (m_match(s.exv, x, s.exd, zr) && !s.expend) return {2'b01, s.exdata};
        if (m_match(s.wbv, x, s.wbd, zr)) return {2'b10, s.wbdata};
        return {2'b00, rf};
    endfunction

    function automatic out_t model_next(out_t q, stim_t s, bit zr);
        out_t n;
        logic [DW+1:0] pa, pb;
        n = q;
        if (s.reset || s.flush) begin
            n = '0;
        end else if (s.stall) begin
            n = q;
        end else if (model_haz(s, zr)) begin
            n.ov = 1'b0; n.opc = '0; n.dest = '0; n.sa = 2'b00; n.sb = 2'b00;
        end else begin
            pa = m_opnd(s, s.s1, s.d1, zr);
            pb = m_opnd(s, s.s2, s.d2, zr);
            n.a = pa[DW-1:0]; n.sa = pa[DW+1:DW];
            n.b = pb[DW-1:0]; n.sb = pb[DW+1:DW];
            n.imm = s.imm; n.opc = s.opc; n.dest = s.dest; n.ov = s.in_valid;
        end
        return n;
    endfunction

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic cmp_out(input string tag, input out_t a, input out_t e);
        chk({tag, "/a_out"}, a.a, e.a);
        chk({tag, "/b_out"}, a.b, e.b);
        chk({tag, "/imm_out"}, a.imm, e.imm);
        chk({tag, "/opcode_out"}, 32'(a.opc), 32'(e.opc));
        chk({tag, "/dest_out"}, 32'(a.dest), 32'(e.dest));
        chk({tag, "/out_valid"}, 32'(a.ov), 32'(e.ov));
        chk({tag, "/fwd_sel_a"}, 32'(a.sa), 32'(e.sa));
        chk({tag, "/fwd_sel_b"}, 32'(a.sb), 32'(e.sb));
    endtask

    function automatic out_t mk(logic [DW-1:0] a, logic [DW-1:0] b, logic [DW-1:0] imm,
                                logic [OW-1:0] opc, logic [RW-1:0] dest, logic ov,
                                logic [1:0] sa, logic [1:0] sb);
        out_t o;
        o.a = a; o.b = b; o.imm = imm; o.opc = opc; o.dest = dest;
        o.ov = ov; o.sa = sa; o.sb = sb;
        return o;
    endfunction

    function automatic stim_t base_stim();
        stim_t s;
        s = '0;
        s.in_valid = 1'b1; s.opc = 5'h01; s.dest = 4'h1; s.s1 = 4'd3; s.s2 = 4'd4;
        s.imm = 32'h99; s.d1 = 32'h11; s.d2 = 32'h22;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.reset    = ($urandom_range(49) == 0);
        s.in_valid = ($urandom_range(3) != 0);
        s.opc      = OW'($urandom);
        s.dest     = RW'($urandom);
        s.s1       = RW'($urandom_range(3));
        s.s2       = RW'($urandom_range(3));
        s.imm      = $urandom;
        s.d1       = $urandom;
        s.d2       = $urandom;
        s.exv      = ($urandom_range(1) != 0);
        s.exd      = RW'($urandom_range(3));
        s.exdata   = $urandom;
        s.expend   = ($urandom_range(2) == 0);
        s.wbv      = ($urandom_range(1) != 0);
        s.wbd      = RW'($urandom_range(3));
        s.wbdata   = $urandom;
        s.stall    = ($urandom_range(5) == 0);
        s.flush    = ($urandom_range(15) == 0);
        return s;
    endfunction

    // Applies one stimulus for one clock. Both DUTs are always compared with
    // the model; with use_c set DUT0 is also compared with fixed constants.
    task automatic cycle(input stim_t s, input string tag, input bit use_c,
                         input out_t ec, input logic hc);
        cur = s;
        #4;
        chk({tag, "/haz_z0"}, 32'(bus0.hazard_stall), 32'(model_haz(s, 1'b0)));
        chk({tag, "/haz_z1"}, 32'(bus1.hazard_stall), 32'(model_haz(s, 1'b1)));
        if (use_c) chk({tag, "/haz_const"}, 32'(bus0.hazard_stall), 32'(hc));
        exp0 = model_next(exp0, s, 1'b0);
        exp1 = model_next(exp1, s, 1'b1);
        @(posedge clk);
        #1;
        cmp_out({tag, "/z0"}, act0, exp0);
        cmp_out({tag, "/z1"}, act1, exp1);
        if (use_c) cmp_out({tag, "/const"}, act0, ec);
    endtask

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    vec_t  tbl[8];
    stim_t s;
    out_t  e_base;
    out_t  e_last;

    initial begin
        checks   = 0;
        failures = 0;
        exp0     = '0;
        exp1     = '0;
        cur      = '0;
        cur.reset = 1'b1;

        e_base = mk(32'h11, 32'h22, 32'h99, 5'h01, 4'h1, 1'b1, 2'b00, 2'b00);

        // Vectors run back to back; each expectation assumes the one before.
        tbl[0].s = base_stim();
        tbl[0].e = e_base; tbl[0].haz = 1'b0;

        tbl[1].s = base_stim();
        tbl[1].s.s1 = 4'd5; tbl[1].s.s2 = 4'd5;
        tbl[1].s.exv = 1'b1; tbl[1].s.exd = 4'd5; tbl[1].s.exdata = 32'hAAAA;
        tbl[1].s.wbv = 1'b1; tbl[1].s.wbd = 4'd5; tbl[1].s.wbdata = 32'hBBBB;
        tbl[1].e = mk(32'hAAAA, 32'hAAAA, 32'h99, 5'h01, 4'h1, 1'b1, 2'b01, 2'b01);
        tbl[1].haz = 1'b0;

        tbl[2].s = tbl[1].s; tbl[2].s.exv = 1'b0;
        tbl[2].e = mk(32'hBBBB, 32'hBBBB, 32'h99, 5'h01, 4'h1, 1'b1, 2'b10, 2'b10);
        tbl[2].haz = 1'b0;

        tbl[3].s = base_stim();
        tbl[3].s.s2 = 4'd7; tbl[3].s.exv = 1'b1; tbl[3].s.exd = 4'd7; tbl[3].s.expend = 1'b1;
        tbl[3].e = mk(32'hBBBB, 32'hBBBB, 32'h99, 5'h00, 4'h0, 1'b0, 2'b00, 2'b00);
        tbl[3].haz = 1'b1;

        tbl[4].s = tbl[3].s; tbl[4].s.expend = 1'b0; tbl[4].s.exdata = 32'h1234;
        tbl[4].e = mk(32'h11, 32'h1234, 32'h99, 5'h01, 4'h1, 1'b1, 2'b00, 2'b01);
        tbl[4].haz = 1'b0;

        tbl[5].s = base_stim(); tbl[5].s.in_valid = 1'b0; tbl[5].s.opc = 5'h02;
        tbl[5].e = mk(32'h11, 32'h22, 32'h99, 5'h02, 4'h1, 1'b0, 2'b00, 2'b00);
        tbl[5].haz = 1'b0;

        tbl[6].s = base_stim(); tbl[6].s.flush = 1'b1;
        tbl[6].e = '0; tbl[6].haz = 1'b0;

        tbl[7].s = base_stim(); tbl[7].s.imm = 32'hDEADBEEF; tbl[7].s.opc = 5'h03;
        tbl[7].e = mk(32'h11, 32'h22, 32'hDEADBEEF, 5'h03, 4'h1, 1'b1, 2'b00, 2'b00);
        tbl[7].haz = 1'b0;

        @(posedge clk);
        #1;

        // Reset with random inputs, including a would-be load-use hazard.
        for (int i = 0; i < 2; i++) begin
            s = rand_stim();
            s.reset = 1'b1; s.in_valid = 1'b1; s.exv = 1'b1; s.exd = s.s1; s.expend = 1'b1;
            s.stall = 1'b0;
            cycle(s, "reset", 1'b1, '0, 1'b0);
        end

        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].s, $sformatf("vec%0d", i), 1'b1, tbl[i].e, tbl[i].haz);
        end

        // Stall for three cycles with changing inputs: outputs stay at vec7.
        e_last = tbl[7].e;
        for (int i = 0; i < 3; i++) begin
            s = rand_stim();
            s.reset = 1'b0; s.flush = 1'b0; s.stall = 1'b1; s.expend = 1'b0;
            cycle(s, $sformatf("stall%0d", i), 1'b1, e_last, 1'b0);
        end
        s = base_stim(); s.stall = 1'b1; s.flush = 1'b1;
        cycle(s, "flush_stall", 1'b1, '0, 1'b0);

        // Reset on top of a hazard, then no leftover bubble.
        cycle(base_stim(), "pre_rst_haz", 1'b1, e_base, 1'b0);
        s = tbl[3].s; s.reset = 1'b1;
        cycle(s, "rst_haz", 1'b1, '0, 1'b0);
        cycle(base_stim(), "post_rst_haz", 1'b1, e_base, 1'b0);

        // Reset on top of a stall.
        s = base_stim(); s.stall = 1'b1; s.reset = 1'b1;
        cycle(s, "rst_stall", 1'b1, '0, 1'b0);
        cycle(base_stim(), "post_rst_stall", 1'b1, e_base, 1'b0);

        // Register 0 against a pending execute write to register 0.
        s = base_stim(); s.s1 = 4'd0; s.exv = 1'b1; s.exd = 4'd0; s.expend = 1'b1;
        s.exdata = 32'h5555;
        cycle(s, "zero_reg", 1'b1,
              mk(32'h11, 32'h22, 32'h99, 5'h00, 4'h0, 1'b0, 2'b00, 2'b00), 1'b1);
        chk("zero_reg/z1_haz", 32'(bus1.hazard_stall), 32'h0);
        chk("zero_reg/z1_a_out", act1.a, 32'h11);
        chk("zero_reg/z1_sel_a", 32'(act1.sa), 32'h0);
        chk("zero_reg/z1_valid", 32'(act1.ov), 32'h1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle(rand_stim(), $sformatf("rand%0d", i), 1'b0, '0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/execute_operand_receiver_fwd.md
Name: execute_operand_receiver_fwd

Overview:
- Parametrised execute-stage input register. Successor to the single-source forwarding receiver.
- Captures the decoded instruction and operands once per cycle. Selects each source operand from one of three places: execute-result forwarding, writeback-result forwarding, or register-file data.
- Adds new behaviour: a valid bit, a downstream stall hold, a flush, load-use hazard detection with bubble insertion, and optional hardwired-zero register exclusion.

Parameters:
- DATA_W, 32, operand/immediate/result width.
- REG_W, 4, register address width.
- OPC_W, 5, opcode width.
- ZERO_REG_EN, 0, when 1, source register 0 is never forwarded and never triggers a hazard.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  decode stage presents a valid instruction.
- opcode_in  in  OPC_W  decoded opcode.
- dest_in  in  REG_W  destination register.
- s1_in  in  REG_W  source 1 register address.
- s2_in  in  REG_W  source 2 register address.
- imm_in  in  DATA_W  immediate data.
- data_s1_in  in  DATA_W  register-file read for s1.
- data_s2_in  in  DATA_W  register-file read for s2.
- ex_fwd_valid  in  1  execute stage holds an instruction that writes ex_fwd_dest.
- ex_fwd_dest  in  REG_W  execute-stage destination.
- ex_fwd_data  in  DATA_W  execute-stage result.
- ex_fwd_pending  in  1  execute-stage result not yet available (load).
- wb_fwd_valid  in  1  writeback stage writes wb_fwd_dest this cycle.
- wb_fwd_dest  in  REG_W  writeback destination.
- wb_fwd_data  in  DATA_W  writeback result.
- stall_in  in  1  downstream cannot accept; hold outputs.
- flush_in  in  1  kill the contents of this stage.
- a_out  out  DATA_W  registered operand A.
- b_out  out  DATA_W  registered operand B.
- imm_out  out  DATA_W  registered immediate.
- opcode_out  out  OPC_W  registered opcode.
- dest_out  out  REG_W  registered destination.
- out_valid  out  1  registered outputs hold a live instruction.
- fwd_sel_a  out  2  registered source of a_out: 00 regfile, 01 execute, 10 writeback.
- fwd_sel_b  out  2  registered source of b_out, same encoding as fwd_sel_a.
- hazard_stall  out  1  combinational request to upstream to hold its inputs.

Behaviour:
- Reset: every registered output is 0, including out_valid, fwd_sel_a and fwd_sel_b. hazard_stall is 0 while reset=1.
- Latency is 1 cycle from the inputs to the registered outputs.
- Match rule: source x matches stage S when S_fwd_valid=1 and x==S_fwd_dest. If ZERO_REG_EN=1, x==0 never matches.
- Hazard: hazard_stall=1 when all of the following hold: in_valid=1, ex_fwd_pending=1, and s1 or s2 matches the execute stage.
- Operand select for A (B is identical with s2 / data_s2_in):
  - execute match with ex_fwd_pending=0 gives ex_fwd_data, sel 01.
  - otherwise a writeback match gives wb_fwd_data, sel 10.
  - otherwise data_s1_in, sel 00.
  - Execute has priority over writeback when both match.
- Per-edge priority, highest first:
  - reset.
  - flush_in: out_valid=0 and all data/opcode/dest/sel outputs cleared to 0.
  - stall_in: every output holds its value.
  - hazard_stall: insert a bubble. out_valid=0, opcode_out=0, dest_out=0, sel=00; a_out, b_out and imm_out hold.
  - normal load: all fields captured, out_valid<=in_valid.
- Upstream must hold its inputs while stall_in or hazard_stall is 1. When the pending load resolves, the next edge captures with execute forwarding.
- in_valid=0 on a normal load: fields are still captured, out_valid=0.
- flush_in and stall_in together: flush wins.
- Reset asserted mid-stall or mid-hazard clears everything on that edge. No residual bubble follows.
- Widths: no arithmetic is done here. All data paths are passed through at DATA_W with no extension.

Test Plan:
- Reset: hold reset 2 cycles with random inputs → all outputs 0. Release → the first captured instruction appears 1 cycle later.
- No forwarding: s1=3, s2=4, data_s1=0x11, data_s2=0x22, no match → a_out=0x11, b_out=0x22, sel=00/00, out_valid=1.
- Priority: s1=s2=5, ex_dest=5 with ex_data=0xAAAA, wb_dest=5 with wb_data=0xBBBB, both valid, pending=0 → a_out=b_out=0xAAAA, sel=01. Drop ex_fwd_valid → 0xBBBB, sel=10.
- Load-use: s2=7, ex_dest=7, pending=1 for 1 cycle, then 0 with ex_data=0x1234 → hazard_stall=1 for one cycle, one bubble (out_valid=0), then b_out=0x1234, sel_b=01, out_valid=1.
- Stall/flush: stall_in=1 for 3 cycles while inputs change → outputs constant. Assert flush_in together with stall_in → next edge out_valid=0 and outputs cleared.
- ZERO_REG_EN=1: s1=0, ex_dest=0, ex_fwd_valid=1, pending=1 → no hazard, a_out=data_s1_in, sel=00. Repeat with ZERO_REG_EN=0 → hazard_stall=1.
